piso_readout_ctrl: RTL and testbench

Sequencer for the testchip error-detector PISO readout. It generates `load` and `shift_clk` toward the testchip, samples the 10 serial channels `Q[9:0]` on every `shift_clk` rising edge, and assembles 10 × 12-bit error counts. Results are published atomically on a flat output bus with a `done` pulse. It sits between the host/UART control logic and the testchip pins, and runs entirely in the FPGA system clock domain. `shift_clk` is a divided, registered output and is not used as an internal clock.

---
 rtl/piso_readout_ctrl.sv | 178 +++++++++++++++++
 tb/tb_piso_readout_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_readout_ctrl.sv
// -----------------------------------------------------------------------------
// piso_readout_ctrl
//
// Readout sequencer for the testchip error-detector PISO chain. It drives the
// parallel-load strobe and a divided shift clock toward the chip. On every
// rising shift_clk edge it samples the NUM_CH serial channels into a shadow
// register. After the last bit it publishes all channel counts at once on
// data_out and pulses done. Everything runs in the clk domain. shift_clk is
// only a registered output and never clocks internal logic.
//
// Parameters
//   CLK_DIV   clk cycles per shift_clk half-period (>= 1)
//   NUM_CH    number of serial channels
//   WIDTH     bits per channel count
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   level, sampled only while idle; starts one readout
//   auto       in   level, sampled in DONE; high chains the next readout
//   Q          in   serial data from the chip, Q[k] = channel k, LSB first
//   shift_clk  out  divided readout clock, idles low
//   load       out  1 = parallel load period, 0 = shift
//   busy       out  high from the cycle after start through DONE
//   done       out  one-cycle pulse; data_out is valid from this cycle
//   data_out   out  channel k at [WIDTH*k +: WIDTH], held between readouts
// -----------------------------------------------------------------------------
module piso_readout_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int NUM_CH  = 10,
    parameter int WIDTH   = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      auto,
    input  logic [NUM_CH-1:0]         Q,
    output logic                      shift_clk,
    output logic                      load,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_CH*WIDTH-1:0]   data_out
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                    state_q;
    logic [DIV_W-1:0]          div_cnt_q;
    logic [DIV_W-1:0]          div_cnt_d;
    logic [BIT_W-1:0]          bit_cnt_q;
    logic                      shift_clk_q;
    logic                      load_q;
    logic                      busy_q;
    logic                      done_q;
    logic [NUM_CH*WIDTH-1:0]   data_out_q;
    logic [NUM_CH*WIDTH-1:0]   cap_flat;
    logic                      div_wrap;
    logic                      capture;

    // The divider reaches its last count on the cycle whose edge toggles
    // shift_clk.
    assign div_wrap  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);

    // This edge drives shift_clk 0->1 during SHIFT. Q still holds the bit the
    // chip presented for this period, because the chip shifts only after it
    // sees the rising edge.
    assign capture = (state_q == S_SHIFT) && div_wrap && !shift_clk_q;

    // Per-channel shadow registers. bit_cnt selects the bit position, so the
    // LSB lands first.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cap
        logic [WIDTH-1:0] cap_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cap_q <= '0;
            end else if (capture) begin
                cap_q[bit_cnt_q] <= Q[gi];
            end
        end

        assign cap_flat[gi*WIDTH +: WIDTH] = cap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_clk_q <= 1'b0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_out_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    shift_clk_q <= 1'b0;
                    load_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    if (start) begin
                        state_q   <= S_LOAD;
                        div_cnt_q <= '0;
                        load_q    <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end

                S_LOAD: begin
                    div_cnt_q <= div_cnt_d;
                    if (div_wrap) begin
                        shift_clk_q <= ~shift_clk_q;
                        // The falling edge closes the single load period.
                        if (shift_clk_q) begin
                            state_q   <= S_SHIFT;
                            bit_cnt_q <= '0;
                            load_q    <= 1'b0;
                        end
                    end
                end

                S_SHIFT: begin
                    div_cnt_q <= div_cnt_d;
                    if (div_wrap) begin
                        shift_clk_q <= ~shift_clk_q;
                        // Falling edges close shift periods. The MSB was
                        // captured half a period earlier, so cap is complete
                        // here.
                        if (shift_clk_q) begin
                            if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
                                data_out_q <= cap_flat;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            end
                        end
                    end
                end

                S_DONE: begin
                    done_q      <= 1'b0;
                    shift_clk_q <= 1'b0;
                    if (auto) begin
                        // Chain directly into the next load with no idle gap.
                        state_q   <= S_LOAD;
                        div_cnt_q <= '0;
                        load_q    <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign shift_clk = shift_clk_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_piso_readout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_readout_ctrl
//
// Four controller instances share clk, rst_n, start and auto. They use
// shift-clock dividers D = 2, 1, 3 and 8. Each instance drives its own
// behavioural PISO chip model. On a rising shift_clk with load high, the chip
// loads either a table pattern or random counts. With load low it shifts each
// channel right, presenting the LSB on Q.
//
// The reference model tracks only the readout start edge E0 for each instance.
// It derives every output from the timing formulas relative to E0:
//   load high for 2D cycles, shift_clk high when (r/D) is odd,
//   done at r = 26D, busy over 0..26D.
// data_out is expected to equal whatever the chip loaded for that readout.
// -----------------------------------------------------------------------------
module tb_piso_readout_ctrl;

    localparam int NI = 4;
    localparam int NC = 10;
    localparam int W  = 12;
    localparam int BW = NC * W;

    function automatic int d_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 8;
        endcase
    endfunction

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          auto_en = 1'b0;
    logic          rand_mode = 1'b0;
    logic [BW-1:0] chip_pat = '0;

    always #5 clk = ~clk;

    logic [NI-1:0] sclk_w, load_w, busy_w, done_w;
    logic [BW-1:0] dout_w      [NI];
    logic [BW-1:0] last_load_w [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        logic [NC-1:0] q;
        logic [BW-1:0] sh;
        logic [BW-1:0] ld_val;
        logic [BW-1:0] v;

        piso_readout_ctrl #(
            .CLK_DIV (d_of(gi)),
            .NUM_CH  (NC),
            .WIDTH   (W)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .auto      (auto_en),
            .Q         (q),
            .shift_clk (sclk_w[gi]),
            .load      (load_w[gi]),
            .busy      (busy_w[gi]),
            .done      (done_w[gi]),
            .data_out  (dout_w[gi])
        );

        // Behavioural testchip: parallel load or LSB-first shift on shift_clk.
        always @(posedge sclk_w[gi]) begin
            if (load_w[gi]) begin
                v = chip_pat;
                if (rand_mode) begin
                    for (int k = 0; k < NC; k++) v[k*W +: W] = W'($urandom);
                end
                sh     <= v;
                ld_val <= v;
            end else begin
                for (int k = 0; k < NC; k++) sh[k*W +: W] <= {1'b0, sh[k*W+1 +: W-1]};
            end
        end

        for (genvar gk = 0; gk < NC; gk++) begin : g_q
            assign q[gk] = sh[gk*W];
        end

        assign last_load_w[gi] = ld_val;
    end

    // ---------------- reference model ----------------
    int            n;
    int            e0       [NI];
    bit            act      [NI];
    logic [BW-1:0] exp_data [NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                act[i]      <= 1'b0;
                e0[i]       <= 0;
                exp_data[i] <= '0;
            end
        end else begin
            n <= n + 1;
            for (int i = 0; i < NI; i++) begin
                if (act[i] && (n + 1 - e0[i]) == 26 * d_of(i) + 1) begin
                    if (auto_en) e0[i] <= n + 1;
                    else         act[i] <= 1'b0;
                end else if (!act[i] && start) begin
                    act[i] <= 1'b1;
                    e0[i]  <= n + 1;
                end
                if (act[i] && (n + 1 - e0[i]) == 26 * d_of(i)) exp_data[i] <= last_load_w[i];
            end
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int tick_cnt = 0;
    int rises     [NI];
    int load_cyc  [NI];
    int done_cnt  [NI];
    int done_tick [NI];
    bit sclk_prev [NI];

    task automatic check(input string nm, input int i, input logic [BW-1:0] got,
                         input logic [BW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d D=%0d: got %h, expected %h", nm, i, d_of(i), got, exp);
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NI; i++) begin
            rises[i] = 0; load_cyc[i] = 0; done_cnt[i] = 0; done_tick[i] = 0;
        end
    endtask

    // One cycle: wait for the falling edge, compare every instance with the
    // model, and accumulate edge statistics.
    task automatic tick();
        int r;
        int dd;
        logic [3:0] exp_ctl;
        @(negedge clk);
        tick_cnt++;
        for (int i = 0; i < NI; i++) begin
            dd = d_of(i);
            r  = n - e0[i];
            exp_ctl = {act[i], act[i] && (r < 2 * dd), act[i] && ((r / dd) % 2 == 1),
                       act[i] && (r == 26 * dd)};
            check("ctl{busy,load,sclk,done}", i,
                  BW'({busy_w[i], load_w[i], sclk_w[i], done_w[i]}), BW'(exp_ctl));
            check("data_out", i, dout_w[i], exp_data[i]);
            if (sclk_w[i] && !sclk_prev[i]) rises[i]++;
            if (load_w[i]) load_cyc[i]++;
            if (done_w[i]) begin
                done_cnt[i]++;
                done_tick[i] = tick_cnt;
            end
            sclk_prev[i] = sclk_w[i];
        end
    endtask

    task automatic wait_idle(input int maxt);
        int k = 0;
        do begin
            tick();
            k++;
        end while (busy_w != '0 && k < maxt);
        check("idle_timeout", 0, BW'(busy_w), '0);
    endtask

    typedef struct {
        string         name;
        logic [BW-1:0] pat;
        logic [BW-1:0] exp;
    } vec_t;

    vec_t tbl [4];

    task automatic run_readout(input vec_t e);
        int st;
        clear_stats();
        chip_pat = e.pat;
        start = 1'b1;
        st = tick_cnt;
        tick();
        start = 1'b0;
        wait_idle(400);
        for (int i = 0; i < NI; i++) begin
            check({e.name, " data"}, i, dout_w[i], e.exp);
            check({e.name, " done_count"}, i, BW'(done_cnt[i]), BW'(1));
            check({e.name, " sclk_rises"}, i, BW'(rises[i]), BW'(13));
            check({e.name, " load_cycles"}, i, BW'(load_cyc[i]), BW'(2 * d_of(i)));
            check({e.name, " latency"}, i, BW'(done_tick[i] - st), BW'(26 * d_of(i) + 1));
            $display("readout %s inst%0d D=%0d: data_out=%h done_count=%0d latency=%0d",
                     e.name, i, d_of(i), dout_w[i], done_cnt[i], done_tick[i] - st);
        end
    endtask

    initial begin
        int nexp;
        int p;

        // Vector table: chip load pattern -> expected data_out.
        tbl[0].name = "ch_k_100";
        tbl[0].pat  = '0;
        for (int k = 0; k < NC; k++) tbl[0].pat[k*W +: W] = W'(12'h100 + k);
        tbl[0].exp  = tbl[0].pat;
        tbl[1].name = "bit_order";
        tbl[1].pat  = '0;
        tbl[1].pat[0*W +: W] = 12'h001;
        tbl[1].pat[5*W +: W] = 12'h800;
        tbl[1].pat[9*W +: W] = 12'hFFF;
        tbl[1].exp  = tbl[1].pat;
        tbl[2].name = "all_ones";
        tbl[2].pat  = '1;
        tbl[2].exp  = '1;
        tbl[3].name = "mixed";
        tbl[3].pat  = '0;
        for (int k = 0; k < NC; k++) tbl[3].pat[k*W +: W] = W'(12'h5A5 ^ (k << 3));
        tbl[3].exp  = tbl[3].pat;
        for (int i = 0; i < NI; i++) sclk_prev[i] = 1'b0;
        clear_stats();

        // Reset state.
        repeat (3) tick();
        for (int i = 0; i < NI; i++) check("reset data_out", i, dout_w[i], '0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Table-driven single readouts.
        for (int t = 0; t < 4; t++) run_readout(tbl[t]);

        // Extra start pulse mid-readout: every instance is busy by then.
        clear_stats();
        chip_pat = tbl[3].pat ^ {BW{1'b1}};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(400);
        for (int i = 0; i < NI; i++) begin
            check("ignore_start done_count", i, BW'(done_cnt[i]), BW'(1));
            check("ignore_start data", i, dout_w[i], tbl[3].pat ^ {BW{1'b1}});
            $display("ignore_start inst%0d D=%0d: done_count=%0d", i, d_of(i), done_cnt[i]);
        end

        // Auto mode with a fresh random load each readout; auto dropped later.
        clear_stats();
        rand_mode = 1'b1;
        auto_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (500) tick();
        auto_en = 1'b0;
        wait_idle(400);
        for (int i = 0; i < NI; i++) begin
            p    = 26 * d_of(i) + 1;
            nexp = 500 / p + 1;
            check("auto done_count", i, BW'(done_cnt[i]), BW'(nexp));
            $display("auto inst%0d D=%0d: done_count=%0d expected=%0d", i, d_of(i),
                     done_cnt[i], nexp);
        end
        rand_mode = 1'b0;

        // Reset mid-SHIFT: D=2 has just captured bit 6.
        clear_stats();
        chip_pat = tbl[1].pat;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("async_reset ctl", i, BW'({busy_w[i], load_w[i], sclk_w[i], done_w[i]}), '0);
            check("async_reset data_out", i, dout_w[i], '0);
            $display("async_reset inst%0d D=%0d: busy=%0b load=%0b sclk=%0b data_out=%h",
                     i, d_of(i), busy_w[i], load_w[i], sclk_w[i], dout_w[i]);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run_readout(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
